// File: rtl/agg_pkg.sv
// rtl/agg_pkg.sv - shared widths, beat count and FSM encoding for the output serializer
package agg_pkg;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int BEATS          = DEF_DATA_WIDTH / DEF_OUT_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  function automatic int beats_of(input int data_width, input int out_width);
    return data_width / out_width;
  endfunction

endpackage

// File: rtl/agg_sync_fifo.sv
// rtl/agg_sync_fifo.sv - synchronous show-ahead FIFO with occupancy count
module agg_sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses writes even when a read happens in the same cycle.
  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/agg_out_serializer.sv
// rtl/agg_out_serializer.sv - buffers wide aggregated words and emits them as narrow beats, LSB beat first
module agg_out_serializer
  import agg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [31:0]                  word_count
);

  localparam int NBEATS = beats_of(DATA_WIDTH, OUT_WIDTH);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  ser_state_e            state_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic [BW-1:0]         beat_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [31:0]           word_count_q;

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr_en;
  logic                  fifo_rd_en;
  logic                  last_beat;

  assign in_ready   = !reset && !fifo_full;
  assign fifo_wr_en = in_valid && in_ready;

  assign last_beat  = (state_q == ST_SHIFT) && (beat_q == BW'(NBEATS - 1));

  // Pop either to start from idle or to chain the next word onto the final beat without a bubble.
  assign fifo_rd_en = !fifo_empty &&
                      ((state_q == ST_IDLE) || (out_ready && last_beat));

  agg_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifo_wr_en),
    .wr_data_i (in_data),
    .rd_en_i   (fifo_rd_en),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      beat_q       <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_rd_en) begin
            state_q     <= ST_SHIFT;
            sreg_q      <= fifo_rd_data;
            beat_q      <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (NBEATS == 1);
          end
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (last_beat) begin
              word_count_q <= word_count_q + 32'd1;
              if (fifo_rd_en) begin
                sreg_q     <= fifo_rd_data;
                beat_q     <= '0;
                out_last_q <= (NBEATS == 1);
              end else begin
                state_q     <= ST_IDLE;
                sreg_q      <= '0;
                beat_q      <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end
            end else begin
              // The low slice of the shift register is always the beat on the bus.
              sreg_q     <= sreg_q >> OUT_WIDTH;
              beat_q     <= beat_q + BW'(1);
              out_last_q <= (beat_q == BW'(NBEATS - 2));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data   = sreg_q[OUT_WIDTH-1:0];
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign word_count = word_count_q;

endmodule
